bus_interconnect: RTL and testbench
===================================

Name: bus_interconnect

Overview:
- Parametrised memory-mapped interconnect between the picorv32 native memory port and N slave regions (memory, io_register, future peripherals).
- Replaces ad-hoc per-region compare logic with a generic block:
  - base/mask region decode, registered slave enables
  - per-slave ready/rdata multiplexing
  - instruction-fetch permission checking
  - error responses, so the CPU never hangs on an unmapped address.

Parameters:
- SLAVES, 3, number of slave regions (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (strobe width = DATA_WIDTH/8).
- SLAVE_BASE, {32'h1000_0000, 32'h0000_1000, 32'h0000_0000}, flattened SLAVES*ADDR_WIDTH bases; slave i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000}, flattened match masks; a 1 bit means compared.
- EXEC_MASK, 3'b001, bit i set = slave i permits instruction fetch.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on any error response.
- TIMEOUT, 255, cycles in ACCESS before timeout (only with BUS_TIMEOUT_EN).

Ports:
- clk_in  in  1  system clock
- reset_n_in  in  1  reset; one clock; reset is synchronous and active-low
- mem_valid_in  in  1  CPU request valid
- mem_instr_in  in  1  request is an instruction fetch
- mem_addr_in  in  ADDR_WIDTH  CPU address
- mem_wdata_in  in  DATA_WIDTH  CPU write data
- mem_wstrb_in  in  DATA_WIDTH/8  byte write strobes; 0 = read
- mem_ready_out  out  1  one-cycle transfer-complete pulse to CPU
- mem_rdata_out  out  DATA_WIDTH  read data to CPU, valid while mem_ready_out
- sel_enable_out  out  SLAVES  one-hot slave enable
- addr_out  out  ADDR_WIDTH  registered slave address
- wdata_out  out  DATA_WIDTH  registered write data
- wstrb_out  out  DATA_WIDTH/8  registered strobes
- slave_ready_in  in  SLAVES  per-slave ready
- slave_rdata_in  in  SLAVES*DATA_WIDTH  flattened per-slave read data
- err_clr_in  in  1  clears sticky error state
- err_out  out  1  sticky error flag
- err_cause_out  out  2  01 unmapped, 10 exec violation, 11 timeout
- err_addr_out  out  ADDR_WIDTH  address of first error since last clear

Behaviour:
- Reset values: all outputs 0; state IDLE.
  - Reset mid-transaction aborts it: enables drop, no mem_ready pulse is issued.
- FSM IDLE -> ACCESS -> RESP -> IDLE; error path IDLE -> RESP.
- IDLE, when mem_valid_in=1:
  - Latch addr, wdata and wstrb into the *_out registers.
  - Decode hit[i] = ((mem_addr_in ^ BASE_i) & MASK_i) == 0; lowest index wins on overlap.
  - No hit: unmapped error, go to RESP.
  - Hit on slave i with mem_instr_in=1 and EXEC_MASK[i]=0: exec violation, go to RESP.
  - Otherwise: sel_enable_out[i]=1, go to ACCESS.
- Error requests never assert any enable, so writes are discarded.
- ACCESS: hold the enable until slave_ready_in[i]=1. On that edge:
  - capture slave_rdata_in[i] (reads only; writes capture 0)
  - clear enable
  - go to RESP
- Ready from non-selected slaves is ignored.
- RESP: mem_ready_out=1 for exactly one cycle.
  - mem_rdata_out = captured data, or ERR_DATA on error.
  - Then IDLE; mem_rdata_out returns to 0.
- Latency: request sampled at cycle N, enable high N+1; slave ready at cycle M gives mem_ready_out at M+1. Minimum is mem_ready_out at N+2. Error response is at N+1.
- A new request is accepted no earlier than the cycle after RESP.
- Error capture:
  - err_out is sticky.
  - err_cause_out and err_addr_out are recorded only when err_out=0 (first error kept).
  - err_clr_in clears all three.
  - err_clr_in in the same cycle as a new error: the new error is recorded.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - After TIMEOUT cycles without slave ready: drop enable, record cause 11, RESP with ERR_DATA.
  - A ready arriving on the same cycle as expiry wins; it is a normal completion.
- Undefined: no counter, and ACCESS waits indefinitely. Cause 11 is never produced.

Decomposition:
- Package bus_pkg holds:
  - FSM state enum (IDLE, ACCESS, RESP)
  - error cause constants (ERR_NONE, ERR_UNMAPPED, ERR_EXEC, ERR_TIMEOUT)
- One sub-module, addr_match: a single-region base/mask comparator with exec check, generate-instantiated SLAVES times.

Test Plan:
- Fetch 0x0000_0010, instr=1; rom ready 1 cycle after enable, rdata 0x0000_0013 -> sel_enable_out=001; mem_ready_out pulses with rdata 0x0000_0013 at N+3.
- Write 0x0000_1004, wdata 0xCAFE_F00D, wstrb 1111 -> sel_enable_out=010, wdata_out=0xCAFE_F00D; single mem_ready_out pulse, err_out=0.
- Read 0x2000_0000 -> mem_ready_out at N+1, rdata 0xDEAD_BEEF, err_out=1, cause 01, err_addr 0x2000_0000, no enable asserted.
- Fetch 0x1000_0000 (instr=1) after the previous error -> ERR_DATA response; err_out stays 1, cause stays 01 (first error kept); pulse err_clr_in -> all three cleared.
- With BUS_TIMEOUT_EN: read 0x1000_0004, io never ready -> enable high for 255 cycles, then mem_ready_out with 0xDEAD_BEEF, cause 11.
- Reset asserted during ACCESS -> next cycle enables 0, state IDLE, no mem_ready_out pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the picorv32 bus interconnect: transaction FSM states and
// the error cause encodings reported on err_cause_out.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_EXEC     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/addr_match.sv
// Single-region base/mask comparator with instruction-fetch permission check.
module addr_match #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
    parameter logic [ADDR_WIDTH-1:0] MASK       = '0,
    parameter logic                  EXEC       = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_instr,
    output logic                  o_hit,
    output logic                  o_exec_ok
);

    assign o_hit     = ((i_addr ^ BASE) & MASK) == '0;
    assign o_exec_ok = EXEC || !i_instr;

endmodule

// File: rtl/bus_interconnect.sv
// picorv32 native-port interconnect: region decode, slave handshake, error responses.
// Optional ACCESS watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int                             SLAVES     = 3,
    parameter int                             ADDR_WIDTH = 32,
    parameter int                             DATA_WIDTH = 32,
    parameter logic [SLAVES*ADDR_WIDTH-1:0]   SLAVE_BASE = {32'h1000_0000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [SLAVES*ADDR_WIDTH-1:0]   SLAVE_MASK = {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000},
    parameter logic [SLAVES-1:0]              EXEC_MASK  = 3'b001,
    parameter logic [DATA_WIDTH-1:0]          ERR_DATA   = 32'hDEAD_BEEF,
    parameter int                             TIMEOUT    = 255
) (
    input  logic                         clk_in,
    input  logic                         reset_n_in,
    input  logic                         mem_valid_in,
    input  logic                         mem_instr_in,
    input  logic [ADDR_WIDTH-1:0]        mem_addr_in,
    input  logic [DATA_WIDTH-1:0]        mem_wdata_in,
    input  logic [DATA_WIDTH/8-1:0]      mem_wstrb_in,
    output logic                         mem_ready_out,
    output logic [DATA_WIDTH-1:0]        mem_rdata_out,
    output logic [SLAVES-1:0]            sel_enable_out,
    output logic [ADDR_WIDTH-1:0]        addr_out,
    output logic [DATA_WIDTH-1:0]        wdata_out,
    output logic [DATA_WIDTH/8-1:0]      wstrb_out,
    input  logic [SLAVES-1:0]            slave_ready_in,
    input  logic [SLAVES*DATA_WIDTH-1:0] slave_rdata_in,
    input  logic                         err_clr_in,
    output logic                         err_out,
    output logic [1:0]                   err_cause_out,
    output logic [ADDR_WIDTH-1:0]        err_addr_out
);

    state_t                    r_state, w_next;
    logic [SLAVES-1:0]         w_hit, w_exec_ok, w_dec_sel, r_sel;
    logic                      w_found, w_dec_exec_ok;
    logic                      w_sel_ready, w_tmo;
    logic [DATA_WIDTH-1:0]     w_sel_rdata, r_rdata;
    logic [ADDR_WIDTH-1:0]     r_addr, r_err_addr, w_err_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic                      w_err_evt, r_err;
    logic [1:0]                w_err_cause, r_err_cause;

    for (genvar g = 0; g < SLAVES; g++) begin : g_match
        addr_match #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .BASE       (SLAVE_BASE[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .MASK       (SLAVE_MASK[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .EXEC       (EXEC_MASK[g])
        ) u_match (
            .i_addr    (mem_addr_in),
            .i_instr   (mem_instr_in),
            .o_hit     (w_hit[g]),
            .o_exec_ok (w_exec_ok[g])
        );
    end

    // Overlapping regions resolve to the lowest slave index.
    always_comb begin
        w_found       = 1'b0;
        w_dec_sel     = '0;
        w_dec_exec_ok = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            if (w_hit[i] && !w_found) begin
                w_found       = 1'b1;
                w_dec_sel[i]  = 1'b1;
                w_dec_exec_ok = w_exec_ok[i];
            end
        end
    end

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (r_sel[i]) begin
                w_sel_ready = w_sel_ready | slave_ready_in[i];
                w_sel_rdata = w_sel_rdata | slave_rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in || r_state != ACCESS) r_tmo_cnt <= '0;
        else                                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_tmo = (r_state == ACCESS) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) r_state <= IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_err_evt   = 1'b0;
        w_err_cause = ERR_NONE;
        w_err_addr  = mem_addr_in;
        case (r_state)
            IDLE: begin
                if (mem_valid_in) begin
                    if (!w_found) begin
                        w_next      = RESP;
                        w_err_evt   = 1'b1;
                        w_err_cause = ERR_UNMAPPED;
                    end else if (!w_dec_exec_ok) begin
                        w_next      = RESP;
                        w_err_evt   = 1'b1;
                        w_err_cause = ERR_EXEC;
                    end else begin
                        w_next      = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A ready coinciding with expiry is a normal completion.
                if (w_sel_ready) begin
                    w_next      = RESP;
                end else if (w_tmo) begin
                    w_next      = RESP;
                    w_err_evt   = 1'b1;
                    w_err_cause = ERR_TIMEOUT;
                    w_err_addr  = r_addr;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rdata <= '0;
                    if (mem_valid_in) begin
                        r_addr  <= mem_addr_in;
                        r_wdata <= mem_wdata_in;
                        r_wstrb <= mem_wstrb_in;
                        if (w_next == ACCESS) r_sel   <= w_dec_sel;
                        else                  r_rdata <= ERR_DATA;
                    end
                end
                ACCESS: begin
                    if (w_sel_ready) begin
                        r_sel   <= '0;
                        r_rdata <= (r_wstrb == '0) ? w_sel_rdata : '0;
                    end else if (w_tmo) begin
                        r_sel   <= '0;
                        r_rdata <= ERR_DATA;
                    end
                end
                default: r_rdata <= '0;
            endcase
        end
    end

    // A clear in the same cycle as a new error still records the new error.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_err       <= 1'b0;
            r_err_cause <= ERR_NONE;
            r_err_addr  <= '0;
        end else if (w_err_evt && (!r_err || err_clr_in)) begin
            r_err       <= 1'b1;
            r_err_cause <= w_err_cause;
            r_err_addr  <= w_err_addr;
        end else if (err_clr_in) begin
            r_err       <= 1'b0;
            r_err_cause <= ERR_NONE;
            r_err_addr  <= '0;
        end
    end

    assign mem_ready_out  = (r_state == RESP);
    assign mem_rdata_out  = (r_state == RESP) ? r_rdata : '0;
    assign sel_enable_out = r_sel;
    assign addr_out       = r_addr;
    assign wdata_out      = r_wdata;
    assign wstrb_out      = r_wstrb;
    assign err_out        = r_err;
    assign err_cause_out  = r_err_cause;
    assign err_addr_out   = r_err_addr;

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect: driver pushes expected responses,
// a negedge monitor pops and compares whenever mem_ready_out is seen.
module tb_bus_interconnect;

    localparam int S   = 3;
    localparam int TMO = 255;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic [31:0] base_t [S] = '{32'h0000_0000, 32'h0000_1000, 32'h1000_0000};
    logic [31:0] mask_t [S] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00};
    logic        exec_t [S] = '{1'b1, 1'b0, 1'b0};

    logic          clk = 0;
    logic          reset_n = 0;
    logic          mem_valid = 0, mem_instr = 0, err_clr = 0;
    logic [31:0]   mem_addr = '0, mem_wdata = '0;
    logic [3:0]    mem_wstrb = '0;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [S-1:0]  sel_en;
    logic [31:0]   addr_o, wdata_o;
    logic [3:0]    wstrb_o;
    logic [S-1:0]  slave_ready = '0;
    logic [S*32-1:0] slave_rdata = '0;
    logic          err_o;
    logic [1:0]    err_cause;
    logic [31:0]   err_addr;

    bus_interconnect dut (
        .clk_in(clk), .reset_n_in(reset_n),
        .mem_valid_in(mem_valid), .mem_instr_in(mem_instr), .mem_addr_in(mem_addr),
        .mem_wdata_in(mem_wdata), .mem_wstrb_in(mem_wstrb),
        .mem_ready_out(mem_ready), .mem_rdata_out(mem_rdata),
        .sel_enable_out(sel_en), .addr_out(addr_o), .wdata_out(wdata_o), .wstrb_out(wstrb_o),
        .slave_ready_in(slave_ready), .slave_rdata_in(slave_rdata),
        .err_clr_in(err_clr), .err_out(err_o), .err_cause_out(err_cause), .err_addr_out(err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] eaddr;
        logic [S-1:0] sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t q[$];
    int vectors = 0, miscompares = 0;

    logic        m_err = 0;
    logic [1:0]  m_cause = 0;
    logic [31:0] m_eaddr = 0;

    int          rsp_delay = 0;
    logic [31:0] rsp_data = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Slave side: selected slave answers after rsp_delay cycles; others babble.
    int en_cnt = 0;
    logic [S-1:0] noise;
    always @(negedge clk) begin
        noise = S'($urandom);
        slave_ready = noise & ~sel_en;
        for (int i = 0; i < S; i++) slave_rdata[i*32 +: 32] = $urandom;
        if (sel_en != '0) begin
            if (en_cnt == rsp_delay) begin
                slave_ready = slave_ready | sel_en;
                for (int i = 0; i < S; i++)
                    if (sel_en[i]) slave_rdata[i*32 +: 32] = rsp_data;
            end
            en_cnt++;
        end else begin
            en_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (sel_en != '0) begin
                if (q.size() == 0) chk("enable_unexpected", 32'(sel_en), 32'h0);
                else               chk("enable", 32'(sel_en), 32'(q[0].sel));
            end
            if (!mem_ready) chk("rdata_idle", mem_rdata, 32'h0);
            if (mem_ready) begin
                if (q.size() == 0) begin
                    chk("ready_unexpected", 32'(mem_ready), 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", mem_rdata, e.rdata);
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                    chk("err_out", 32'(err_o), 32'(e.err));
                    chk("err_cause", 32'(err_cause), 32'(e.cause));
                    chk("err_addr", err_addr, e.eaddr);
                    chk("addr_out", addr_o, e.addr);
                    chk("wdata_out", wdata_o, e.wdata);
                    chk("wstrb_out", 32'(wstrb_o), 32'(e.wstrb));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [31:0] a, input logic ins, input logic [3:0] ws,
                          input logic [31:0] wd, input int d, input logic clr);
        exp_t e;
        int idx;
        logic ev;
        logic [1:0] cs;
        int k;
        idx = -1;
        for (int i = S - 1; i >= 0; i--)
            if ((a & mask_t[i]) == (base_t[i] & mask_t[i])) idx = i;
        ev = 1'b0;
        cs = 2'b00;
        e.rdata = (ws != 0) ? 32'h0 : rsp_data;
        e.cyc   = cyc + 2 + d;
        e.sel   = '0;
        if (idx < 0) begin
            ev = 1; cs = 2'b01; e.rdata = ERRD; e.cyc = cyc + 1;
        end else if (ins && !exec_t[idx]) begin
            ev = 1; cs = 2'b10; e.rdata = ERRD; e.cyc = cyc + 1;
        end else begin
            e.sel = S'(1) << idx;
`ifdef BUS_TIMEOUT_EN
            if (d > TMO - 1) begin
                ev = 1; cs = 2'b11; e.rdata = ERRD; e.cyc = cyc + 1 + TMO;
            end
`endif
        end
        if (clr) begin m_err = 0; m_cause = 0; m_eaddr = 0; end
        if (ev && !m_err) begin m_err = 1; m_cause = cs; m_eaddr = a; end
        e.err = m_err; e.cause = m_cause; e.eaddr = m_eaddr;
        e.addr = a; e.wdata = wd; e.wstrb = ws;
        rsp_delay = d;
        q.push_back(e);
        mem_valid = 1; mem_instr = ins; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        err_clr = clr;
        tick();
        err_clr = 0;
        k = 0;
        while (!mem_ready && k < TMO + 50) begin
            tick();
            k++;
        end
        if (!mem_ready) begin
            miscompares++;
            $display("FAIL response_timeout: no mem_ready for addr %h", a);
            q.delete();
        end
        mem_valid = 0;
        tick();
    endtask

    task automatic pulse_clr();
        err_clr = 1;
        tick();
        err_clr = 0;
        m_err = 0; m_cause = 0; m_eaddr = 0;
        chk("clr_err", 32'(err_o), 32'h0);
        chk("clr_cause", 32'(err_cause), 32'h0);
        chk("clr_addr", err_addr, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic ins;
        logic [3:0] ws;
        int r;
        repeat (2) tick();
        reset_n = 1;
        chk("rst_ready", 32'(mem_ready), 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_sel", 32'(sel_en), 32'h0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_cause", 32'(err_cause), 32'h0);
        tick();

        rsp_data = 32'h0000_0013;
        do_txn(32'h0000_0010, 1, 4'h0, 32'h0, 1, 0);
        rsp_data = $urandom;
        do_txn(32'h0000_1004, 0, 4'hF, 32'hCAFE_F00D, 2, 0);
        do_txn(32'h2000_0000, 0, 4'h0, 32'h0, 0, 0);
        do_txn(32'h1000_0000, 1, 4'h0, 32'h0, 0, 0);
        pulse_clr();
        do_txn(32'h3000_0000, 0, 4'h0, 32'h0, 0, 0);
        do_txn(32'h0000_1800, 1, 4'h0, 32'h0, 0, 1);
`ifdef BUS_TIMEOUT_EN
        pulse_clr();
        do_txn(32'h1000_0004, 0, 4'h0, 32'h0, 100000, 0);
        rsp_data = 32'h1234_5678;
        do_txn(32'h1000_0008, 0, 4'h0, 32'h0, TMO - 1, 0);
`endif

        // Reset while a slave is stalling: the transaction is dropped silently.
        begin
            exp_t e;
            e.sel = 3'b010;
            q.push_back(e);
            rsp_delay = 100000;
            mem_valid = 1; mem_instr = 0; mem_addr = 32'h0000_1100; mem_wstrb = 0;
            repeat (4) tick();
            reset_n = 0; mem_valid = 0; q.delete();
            tick();
            reset_n = 1;
            m_err = 0; m_cause = 0; m_eaddr = 0;
            chk("midrst_sel", 32'(sel_en), 32'h0);
            chk("midrst_ready", 32'(mem_ready), 32'h0);
            chk("midrst_err", 32'(err_o), 32'h0);
            repeat (5) tick();
        end

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: a = {20'h0, 12'($urandom)};
                1: a = 32'h0000_1000 | {20'h0, 12'($urandom)};
                2: a = 32'h1000_0000 | {24'h0, 8'($urandom)};
                3: a = $urandom;
                default: a = 32'h1000_0100 | {24'h0, 8'($urandom)};
            endcase
            ins = ($urandom_range(0, 3) == 0);
            ws = (ins || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            rsp_data = $urandom;
            do_txn(a, ins, ws, $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end

        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected: %0d responses never seen", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
